// File: rtl/ras_linked_stack.sv
// ============================================================================
// Module      : ras_linked_stack
// Description : Return-address stack kept as a linked list of nodes. Each
//               node stores a return address and the index of the node below
//               it. Node indices come from an external memory allocator,
//               which this block drives through alloc / de_alloc /
//               last_alloc_addr. A flush walks the list and frees one node
//               per cycle.
// Ports       : clk, reset            clock, async active-high reset
//               push, pop, push_data  call / return requests
//               flush                 discard the whole stack (multi-cycle)
//               busy                  flush walk in progress
//               top_data, top_valid   zero-latency top of stack
//               count, full           live node count, count == DEPTH
//               overflow, underflow   sticky dropped-push / dropped-pop flags
//               alloc, alloc_addr     take the allocator's next free node
//               de_alloc,
//               last_alloc_addr       return the top node to the allocator
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ras_linked_stack #(
    parameter int ADDR  = 4,
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] top_data,
    output logic             top_valid,
    output logic [ADDR:0]    count,
    output logic             full,
    output logic             overflow,
    output logic             underflow,
    output logic             alloc,
    input  logic [ADDR-1:0]  alloc_addr,
    output logic             de_alloc,
    output logic [ADDR-1:0]  last_alloc_addr
);

    localparam logic [ADDR:0] c_depth = (ADDR+1)'(DEPTH);
    localparam logic [ADDR:0] c_one   = (ADDR+1)'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR-1:0]   r_top_ptr;
    logic [ADDR:0]     r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [WIDTH-1:0]  r_node_data [DEPTH];
    logic [ADDR-1:0]   r_node_prev [DEPTH];

    logic              w_alloc;
    logic              w_de_alloc;
    logic              w_tail;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic              w_empty;
    logic              w_full;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_depth);

    // ------------------------------------------------------------------------
    // Next-state and allocator handshake decode
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_alloc      = 1'b0;
        w_de_alloc   = 1'b0;
        w_tail       = 1'b0;
        w_ovf_set    = 1'b0;
        w_udf_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    // Flushing an empty stack is a no-op; otherwise the walk
                    // starts next cycle and nothing is freed this cycle.
                    if (!w_empty) begin
                        w_next_state = S_FLUSH;
                    end
                end else if (push && pop && !w_empty) begin
                    // Tail call: overwrite the top in place, list unchanged.
                    w_tail = 1'b1;
                end else if (push) begin
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_alloc = 1'b1;
                    end
                end else if (pop) begin
                    if (w_empty) begin
                        w_udf_set = 1'b1;
                    end else begin
                        w_de_alloc = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                // Free the top node each cycle; leave as the last one goes.
                w_de_alloc = !w_empty;
                if (r_count <= c_one) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_top_ptr   <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (w_alloc) begin
                r_top_ptr <= alloc_addr;
                r_count   <= r_count + c_one;
            end else if (w_de_alloc) begin
                r_top_ptr <= r_node_prev[r_top_ptr];
                r_count   <= r_count - c_one;
            end
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Node storage (contents are not reset)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_node_data[alloc_addr] <= push_data;
            r_node_prev[alloc_addr] <= r_top_ptr;
        end else if (w_tail) begin
            r_node_data[r_top_ptr] <= push_data;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy            = (r_state == S_FLUSH);
    assign top_data        = r_node_data[r_top_ptr];
    assign top_valid       = !w_empty;
    assign count           = r_count;
    assign full            = w_full;
    assign overflow        = r_overflow;
    assign underflow       = r_underflow;
    assign alloc           = w_alloc;
    assign de_alloc        = w_de_alloc;
    assign last_alloc_addr = r_top_ptr;

endmodule

`default_nettype wire

// File: tb/tb_ras_linked_stack.sv
// ============================================================================
// Module      : tb_ras_linked_stack
// Description : Self-checking bench for ras_linked_stack. Includes a LIFO
//               free-list model of the node allocator feeding alloc_addr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ras_linked_stack;

    logic        clk;
    logic        reset;
    logic        push;
    logic        pop;
    logic [31:0] push_data;
    logic        flush;
    logic        busy;
    logic [31:0] top_data;
    logic        top_valid;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic        underflow;
    logic        alloc;
    logic [3:0]  alloc_addr;
    logic        de_alloc;
    logic [3:0]  last_alloc_addr;

    int n_pass  = 0;
    int n_total = 0;

    ras_linked_stack #(.ADDR(4), .DEPTH(16), .WIDTH(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .push            (push),
        .pop             (pop),
        .push_data       (push_data),
        .flush           (flush),
        .busy            (busy),
        .top_data        (top_data),
        .top_valid       (top_valid),
        .count           (count),
        .full            (full),
        .overflow        (overflow),
        .underflow       (underflow),
        .alloc           (alloc),
        .alloc_addr      (alloc_addr),
        .de_alloc        (de_alloc),
        .last_alloc_addr (last_alloc_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Allocator model: LIFO free list, node 0 handed out first; a freed node
    // becomes the next one handed out.
    logic [3:0] fstk [16];
    int         fsp;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) fstk[i] <= 4'(15 - i);
            fsp <= 16;
        end else if (alloc && fsp > 0) begin
            fsp <= fsp - 1;
        end else if (de_alloc && fsp < 16) begin
            fstk[fsp] <= last_alloc_addr;
            fsp       <= fsp + 1;
        end
    end

    always_comb begin
        alloc_addr = 4'd0;
        if (fsp > 0 && fsp <= 16) alloc_addr = fstk[fsp-1];
    end

    typedef struct {
        logic        push;
        logic        pop;
        logic        flush;
        logic [31:0] data;
        logic        e_alloc;
        logic        e_de;
        logic [3:0]  e_last;
        logic        e_busy;
        logic [4:0]  e_count;
        logic        e_tv;
        logic [31:0] e_top;
        logic        e_full;
        logic        e_ovf;
        logic        e_udf;
    } vec_t;

    function automatic vec_t mk(input logic p, input logic po, input logic f,
                                input logic [31:0] d, input logic ea,
                                input logic ed, input int el, input logic eb,
                                input int ec, input logic etv,
                                input logic [31:0] et, input logic ef,
                                input logic eo, input logic eu);
        vec_t v;
        v.push = p;   v.pop = po;  v.flush = f;  v.data = d;
        v.e_alloc = ea; v.e_de = ed; v.e_last = 4'(el); v.e_busy = eb;
        v.e_count = 5'(ec); v.e_tv = etv; v.e_top = et;
        v.e_full = ef; v.e_ovf = eo; v.e_udf = eu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Drive one cycle: inputs set after the falling edge, combinational
    // handshake outputs checked before the rising edge, state checked 1
    // time unit after it.
    task automatic run_vec(input vec_t v, input string tag);
        @(negedge clk);
        push = v.push; pop = v.pop; flush = v.flush; push_data = v.data;
        #1;
        chk({tag, " alloc"},    32'(alloc),    32'(v.e_alloc));
        chk({tag, " de_alloc"}, 32'(de_alloc), 32'(v.e_de));
        if (v.e_de) chk({tag, " last_alloc_addr"}, 32'(last_alloc_addr), 32'(v.e_last));
        chk({tag, " busy"},     32'(busy),     32'(v.e_busy));
        @(posedge clk);
        #1;
        chk({tag, " count"},     32'(count),     32'(v.e_count));
        chk({tag, " top_valid"}, 32'(top_valid), 32'(v.e_tv));
        if (v.e_tv) chk({tag, " top_data"}, top_data, v.e_top);
        chk({tag, " full"},      32'(full),      32'(v.e_full));
        chk({tag, " overflow"},  32'(overflow),  32'(v.e_ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(v.e_udf));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t tbl [12];

    // Random-phase reference stack
    logic [31:0] mdata [16];
    logic [3:0]  mnode [16];
    int          mn;
    logic        mo, mu;

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0; push_data = '0;

        // ---- tests 1 and 2 as a vector table ----
        //            p  po f  data          ea ed last b  cnt tv top           f  ov ud
        tbl[0]  = mk(0, 0, 0, 32'h0,        0, 0, 0,  0, 0,  0, 32'h0,       0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 32'h100,      1, 0, 0,  0, 1,  1, 32'h100,     0, 0, 0);
        tbl[2]  = mk(1, 0, 0, 32'h200,      1, 0, 0,  0, 2,  1, 32'h200,     0, 0, 0);
        tbl[3]  = mk(1, 0, 0, 32'h300,      1, 0, 0,  0, 3,  1, 32'h300,     0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 32'h0,        0, 1, 2,  0, 2,  1, 32'h200,     0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 32'h0,        0, 1, 1,  0, 1,  1, 32'h100,     0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 32'h0,        0, 1, 0,  0, 0,  0, 32'h0,       0, 0, 0);
        tbl[7]  = mk(1, 0, 0, 32'hA,        1, 0, 0,  0, 1,  1, 32'hA,       0, 0, 0);
        tbl[8]  = mk(1, 1, 0, 32'hB,        0, 0, 0,  0, 1,  1, 32'hB,       0, 0, 0);
        tbl[9]  = mk(0, 1, 0, 32'h0,        0, 1, 0,  0, 0,  0, 32'h0,       0, 0, 0);
        tbl[10] = mk(1, 1, 0, 32'hC,        1, 0, 0,  0, 1,  1, 32'hC,       0, 0, 0);
        tbl[11] = mk(0, 1, 0, 32'h0,        0, 1, 0,  0, 0,  0, 32'h0,       0, 0, 0);

        do_reset();
        #1;
        chk("reset count",     32'(count),     32'd0);
        chk("reset top_valid", 32'(top_valid), 32'd0);
        chk("reset busy",      32'(busy),      32'd0);
        chk("reset flags",     32'({overflow, underflow, full, alloc, de_alloc}), 32'd0);
        for (int i = 0; i < 12; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // ---- test 3: fill, overflow, drain, underflow ----
        do_reset();
        for (int i = 0; i < 16; i++)
            run_vec(mk(1, 0, 0, 32'h1000 + 32'(i), 1, 0, 0, 0, i + 1, 1,
                       32'h1000 + 32'(i), i == 15, 0, 0), "fill");
        run_vec(mk(1, 0, 0, 32'hDEAD, 0, 0, 0, 0, 16, 1, 32'h100F, 1, 1, 0), "ovf push");
        for (int i = 0; i < 16; i++)
            run_vec(mk(0, 1, 0, 32'h0, 0, 1, 15 - i, 0, 15 - i, i != 15,
                       32'h1000 + 32'(14 - i), 0, 1, 0), "drain");
        run_vec(mk(0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 1, 1), "udf pop");

        // ---- test 4: flush 5 nodes, push during busy ignored ----
        do_reset();
        for (int i = 0; i < 5; i++)
            run_vec(mk(1, 0, 0, 32'h41 + 32'(i), 1, 0, 0, 0, i + 1, 1,
                       32'h41 + 32'(i), 0, 0, 0), "f push");
        run_vec(mk(0, 0, 1, 32'h0, 0, 0, 0, 0, 5, 1, 32'h45, 0, 0, 0), "flush start");
        run_vec(mk(1, 0, 0, 32'hBAD, 0, 1, 4, 1, 4, 1, 32'h44, 0, 0, 0), "flush w1");
        for (int i = 1; i < 5; i++)
            run_vec(mk(0, 0, 0, 32'h0, 0, 1, 4 - i, 1, 4 - i, i != 4,
                       32'h44 - 32'(i), 0, 0, 0), "flush walk");
        run_vec(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0), "flush done");

        // ---- test 5a: freed index is reused ----
        do_reset();
        for (int i = 0; i < 3; i++)
            run_vec(mk(1, 0, 0, 32'h60 + 32'(i), 1, 0, 0, 0, i + 1, 1,
                       32'h60 + 32'(i), 0, 0, 0), "reuse push");
        run_vec(mk(0, 1, 0, 32'h0, 0, 1, 2, 0, 2, 1, 32'h61, 0, 0, 0), "reuse pop");
        #1 chk("reuse alloc_addr", 32'(alloc_addr), 32'd2);
        run_vec(mk(1, 0, 0, 32'h77, 1, 0, 0, 0, 3, 1, 32'h77, 0, 0, 0), "reuse push77");
        run_vec(mk(0, 1, 0, 32'h0, 0, 1, 2, 0, 2, 1, 32'h61, 0, 0, 0), "reuse pop77");

        // ---- test 5b: random push/pop against a reference stack ----
        do_reset();
        mn = 0; mo = 1'b0; mu = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            logic p, po, ea, ed;
            logic [3:0]  el;
            logic [31:0] d;
            int r;
            r  = int'($urandom_range(0, 3));
            // bias toward pushes in the first half, pops in the second
            p  = (c < 500) ? (r != 0) : (r == 0);
            po = (c < 500) ? (r == 0 || r == 3) : (r != 1);
            d  = $urandom;
            ea = 1'b0; ed = 1'b0; el = 4'd0;
            if (p && po && mn > 0) begin
                mdata[mn-1] = d;
            end else if (p) begin
                if (mn == 16) mo = 1'b1;
                else begin
                    ea = 1'b1; mnode[mn] = alloc_addr; mdata[mn] = d; mn++;
                end
            end else if (po) begin
                if (mn == 0) mu = 1'b1;
                else begin
                    ed = 1'b1; el = mnode[mn-1]; mn--;
                end
            end
            run_vec(mk(p, po, 0, d, ea, ed, int'(el), 0, mn, mn > 0,
                       (mn > 0) ? mdata[mn-1] : 32'h0, mn == 16, mo, mu), "rand");
        end

        // ---- test 6: reset in the middle of a flush ----
        do_reset();
        run_vec(mk(0, 1, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1), "r6 udf");
        for (int i = 0; i < 5; i++)
            run_vec(mk(1, 0, 0, 32'h90 + 32'(i), 1, 0, 0, 0, i + 1, 1,
                       32'h90 + 32'(i), 0, 0, 1), "r6 push");
        run_vec(mk(0, 0, 1, 32'h0, 0, 0, 0, 0, 5, 1, 32'h94, 0, 0, 1), "r6 flush");
        run_vec(mk(0, 0, 0, 32'h0, 0, 1, 4, 1, 4, 1, 32'h93, 0, 0, 1), "r6 walk");
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midflush busy",      32'(busy),      32'd0);
        chk("midflush count",     32'(count),     32'd0);
        chk("midflush top_valid", 32'(top_valid), 32'd0);
        chk("midflush flags",     32'({overflow, underflow}), 32'd0);
        chk("midflush de_alloc",  32'(de_alloc),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_vec(mk(0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0), "post reset idle");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
